keypad_scan_ctrl: RTL and testbench

- Scan controller for the 4x4 matrix keypad. Sequences the column strobes, waits for row lines to settle, and samples the rows.
- Debounces the complete 16-key image and reports key-press events to the tone generator / LED path through a valid/ready handshake.
- Runs on the system clock and replaces the free-running scanner fed by the divided clock. The divider is no longer needed for scanning.

---
 rtl/keypad_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scans a 4x4 active-low matrix keypad, debounces the full 16-key image, reports key events.
// Latency: a stable press is reported after DEBOUNCE_SCANS scans of 4*(SETTLE_CYC+1) cycles, plus 2 cycles.
// Backpressure: single event slot on key_valid/key_ready; an event arriving while the slot is full and not
//   being accepted is dropped and latches key_ovf (cleared only by reset).
// Ports: clk, rst (async, active-low); row (in, active-low rows); col (out, active-low one-cold column drive);
//   key_code/key_valid/key_ready event handshake; key_held (debounced image non-zero); key_ovf (sticky drop);
//   diods = {key_held, key_ovf, 2'b00, key_code}.
// Optional: define KPD_AUTOREPEAT_EN to emit repeat events while the selected key stays held.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYC     = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 50000000,
  parameter int REPEAT_RATE    = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       key_ovf,
  output logic [7:0] diods
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic {DRIVE, SAMPLE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    k;
  logic [15:0]   image;
  logic [15:0]   prev_img;
  logic [15:0]   deb;
  logic [SW-1:0] stab, stab_nxt;
  logic          scan_done;
  logic [3:0]    sel_idx, last_idx;
  logic          sel_vld, last_vld;
  logic          chg_evt, rpt_evt, evt;

  // ---------------------------------------------------------------------------
  // Scan sequencer: DRIVE holds column k for SETTLE_CYC cycles, SAMPLE latches rows.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DRIVE;
      cnt   <= '0;
      k     <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == DRIVE) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end else begin
        k <= k + 2'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DRIVE:  if (cnt == CNT_LAST) state_nxt = SAMPLE;
      SAMPLE: state_nxt = DRIVE;
    endcase
  end

  // Column k stays driven through SAMPLE so rows are still valid when latched.
  // Gated by rst so every column is released for the whole reset interval and
  // column 0 is driven from the very first cycle after release.
  assign col = rst ? ~(4'b0001 << k) : 4'b1111;

  // ---------------------------------------------------------------------------
  // Image capture and debounce. The comparison runs one cycle after the last
  // column is latched, when the image register holds a complete scan.
  // ---------------------------------------------------------------------------
  always_comb begin
    stab_nxt = stab;
    if (image == prev_img) begin
      if (stab != STAB_MAX) stab_nxt = stab + 1'b1;
    end else begin
      stab_nxt = SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      image     <= '0;
      prev_img  <= '0;
      deb       <= '0;
      stab      <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= (state == SAMPLE) && (k == 2'd3);
      if (state == SAMPLE) image[{k, 2'b00} +: 4] <= ~row;
      if (scan_done) begin
        stab     <= stab_nxt;
        prev_img <= image;
        if (stab_nxt == STAB_MAX) deb <= image;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Key selection: lowest set index of the debounced image wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_idx = 4'd0;
    sel_vld = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (deb[i]) begin
        sel_idx = 4'(i);
        sel_vld = 1'b1;
      end
    end
  end

  assign key_held = |deb;

  // A release (sel_vld falling) or a higher key joining never changes the
  // selection in a way that counts as an event.
  assign chg_evt = sel_vld && (!last_vld || (sel_idx != last_idx));

`ifdef KPD_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DLY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_RATE = RW'(REPEAT_RATE);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_run;
  logic          rpt_first;

  // rpt_cnt equals the number of cycles since the last emitted event.
  assign rpt_evt = rpt_run && sel_vld && !chg_evt &&
                   (rpt_cnt == (rpt_first ? RPT_DLY : RPT_RATE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt   <= '0;
      rpt_run   <= 1'b0;
      rpt_first <= 1'b0;
    end else if (evt) begin
      rpt_cnt   <= RW'(1);
      rpt_run   <= 1'b1;
      rpt_first <= chg_evt;
    end else if (!key_held) begin
      rpt_cnt <= '0;
      rpt_run <= 1'b0;
    end else if (rpt_run) begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  // Repeat timing parameters have no effect in this build.
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY, REPEAT_RATE};
  assign rpt_evt    = 1'b0;
`endif

  assign evt = chg_evt | rpt_evt;

  // ---------------------------------------------------------------------------
  // Event slot. A new event may replace the pending one only in the cycle it is
  // being accepted; otherwise it is dropped and flagged.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_ovf   <= 1'b0;
      last_vld  <= 1'b0;
      last_idx  <= 4'd0;
    end else begin
      last_vld <= sel_vld;
      last_idx <= sel_idx;
      if (evt) begin
        if (!key_valid || key_ready) begin
          key_code  <= sel_idx;
          key_valid <= 1'b1;
        end else begin
          key_ovf <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

  assign diods = {key_held, key_ovf, 2'b00, key_code};

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: table-driven scan-timing check, directed event/handshake sequences, and a randomized
//   keypad run compared against a scan-level reference model of debounce and key selection.
module tb_keypad_scan_ctrl;

  localparam int SETTLE = 2;
  localparam int DEB    = 2;
  localparam int SCAN   = 4 * (SETTLE + 1);

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic        key_ovf;
  logic [7:0]  diods;
  logic [15:0] pressed;

  int n_vec = 0;
  int n_err = 0;

  // Scan-level reference model state
  int          m_run;
  int          m_nscan;
  logic [15:0] m_last;
  logic [15:0] m_deb;
  logic [3:0]  exp_q[$];
  logic [3:0]  obs_q[$];
  int          rise_q[$];
  int          cyc;
  int          pend;
  logic        vld_q;
  logic        rdy_rand;

  typedef struct {
    logic       rst_in;
    logic [3:0] exp_col;
  } vec_t;
  vec_t vt[26];

  keypad_scan_ctrl #(
    .SETTLE_CYC    (SETTLE),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_DELAY  (100),
    .REPEAT_RATE   (40)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held (key_held),
    .key_ovf  (key_ovf),
    .diods    (diods)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to a column driven low.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && pressed[4*c+r]) row[r] = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int low_idx(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] obs_at(input int i);
    if (i < obs_q.size()) return 32'(obs_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rise_at(input int i);
    if (i < rise_q.size()) return 32'(rise_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // Debounce rule in scan terms: the debounced image takes a scan image once
  // DEB consecutive scans have been identical; an event is a change of the
  // lowest pressed key to some key.
  task automatic model_update(input logic [15:0] img);
    int old_sel;
    int new_sel;
    if (m_nscan > 0 && img == m_last) begin
      if (m_run < DEB) m_run++;
    end else begin
      m_run = 1;
    end
    m_last = img;
    m_nscan++;
    old_sel = low_idx(m_deb);
    if (m_run == DEB) m_deb = img;
    new_sel = low_idx(m_deb);
    if (new_sel >= 0 && new_sel != old_sel) exp_q.push_back(4'(new_sel));
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick();
    if (rdy_rand) key_ready = ($urandom_range(0, 3) != 0) || (pend >= 3);
    if (key_valid && key_ready) obs_q.push_back(key_code);
    if (key_valid && !key_ready) pend++; else pend = 0;
    if (key_valid && !vld_q) rise_q.push_back(cyc);
    vld_q = key_valid;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full scan with the given key image; key_held is checked once the
  // previous scan's debounce result is visible.
  task automatic run_scan(input logic [15:0] img);
    pressed = img;
    tick();
    chk("key_held", 32'(key_held), 32'(m_deb != 16'h0));
    repeat (SCAN - 1) tick();
    model_update(img);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    key_ready = 1'b0;
    pressed   = 16'h0;
    rdy_rand  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_run = 0; m_nscan = 0; m_last = 16'h0; m_deb = 16'h0;
    exp_q.delete(); obs_q.delete(); rise_q.delete();
    cyc = 0; pend = 0; vld_q = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish after 1000000 ns, expected finish earlier");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int          mode;
    int          hold;
    logic [15:0] img;

    rst = 1'b1; key_ready = 1'b0; pressed = 16'h0; rdy_rand = 1'b0;
    cyc = 0; pend = 0; vld_q = 1'b0;
    m_run = 0; m_nscan = 0; m_last = 16'h0; m_deb = 16'h0;

    // ---- column sequence table: 2 cycles in reset, then two scan periods
    for (int i = 0; i < 26; i++) begin
      vt[i].rst_in  = (i >= 2);
      vt[i].exp_col = (i < 2) ? 4'b1111 : ~(4'b0001 << (((i - 2) / 3) % 4));
    end
    @(negedge clk);
    for (int i = 0; i < 26; i++) begin
      rst = vt[i].rst_in;
      #1;
      chk($sformatf("t1_col[%0d]", i), 32'(col), 32'(vt[i].exp_col));
      chk($sformatf("t1_diods[%0d]", i), 32'(diods), 32'h0);
      chk($sformatf("t1_valid[%0d]", i), 32'(key_valid), 32'h0);
      @(negedge clk);
    end

    // ---- single key 9 (col 2, row 1), accept, then ready with nothing pending
    do_reset();
    repeat (2) run_scan(16'h0200);
    chk("t2_no_early_valid", 32'(key_valid), 32'h0);
    run_scan(16'h0200);
    chk("t2_valid", 32'(key_valid), 32'h1);
    chk("t2_code", 32'(key_code), 32'h9);
    chk("t2_diods", 32'(diods), 32'h89);
    key_ready = 1'b1;
    tick();
    chk("t2_valid_clr", 32'(key_valid), 32'h0);
    chk("t2_held", 32'(key_held), 32'h1);
    run_scan(16'h0200);
    chk("t2_no_spurious", 32'(key_valid), 32'h0);

    // ---- reset in the middle of a scan
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("t_rst_col", 32'(col), 32'hF);
    chk("t_rst_diods", 32'(diods), 32'h0);
    chk("t_rst_valid", 32'(key_valid), 32'h0);
    do_reset();
    #1;
    chk("t_rst_restart_col", 32'(col), 32'hE);

    // ---- bouncing key 4: no event until two identical scans
    do_reset();
    key_ready = 1'b1;
    for (int s = 0; s < 5; s++) run_scan((s % 2 == 0) ? 16'h0010 : 16'h0000);
    chk("t3_no_evt", 32'(obs_q.size()), 32'd0);
    repeat (3) run_scan(16'h0010);
    chk("t3_one_evt", 32'(obs_q.size()), 32'd1);
    chk("t3_code", obs_at(0), 32'h4);

    // ---- overflow: key 5 left pending, release, press key 2
    do_reset();
    repeat (3) run_scan(16'h0020);
    repeat (3) run_scan(16'h0000);
    repeat (3) run_scan(16'h0004);
    chk("t4_code_kept", 32'(key_code), 32'h5);
    chk("t4_valid", 32'(key_valid), 32'h1);
    chk("t4_ovf", 32'(key_ovf), 32'h1);
    chk("t4_diods", 32'(diods), 32'hC5);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    tick();
    chk("t4_valid_clr", 32'(key_valid), 32'h0);
    chk("t4_ovf_sticky", 32'(key_ovf), 32'h1);

    // ---- two keys: lowest wins; releasing it reports the other
    do_reset();
    key_ready = 1'b1;
    repeat (3) run_scan(16'h0048);
    chk("t5_first_cnt", 32'(obs_q.size()), 32'd1);
    chk("t5_first_code", obs_at(0), 32'h3);
    repeat (3) run_scan(16'h0040);
    chk("t5_second_code", obs_at(1), 32'h6);
    repeat (3) run_scan(16'h0000);
    chk("t5_release_cnt", 32'(obs_q.size()), 32'd2);
    chk("t5_held_off", 32'(key_held), 32'h0);
    chk("t5_no_ovf", 32'(key_ovf), 32'h0);

    // ---- randomized key images with random ready, against the scan model
    do_reset();
    rdy_rand = 1'b1;
    img = 16'h0;
    for (int g = 0; g < 40; g++) begin
      mode = $urandom_range(0, 3);
      hold = $urandom_range(1, 3);
      case (mode)
        0: img = 16'h0;
        1: img = 16'h1 << $urandom_range(0, 15);
        2: img = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: img = img;
      endcase
      repeat (hold) run_scan(img);
`ifdef KPD_AUTOREPEAT_EN
      repeat (2) run_scan(16'h0);
`endif
    end
    repeat (3) run_scan(16'h0);
    rdy_rand = 1'b0;
    chk("rnd_evt_cnt", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rnd_evt[%0d]", i), obs_at(i), 32'(exp_q[i]));
    chk("rnd_no_ovf", 32'(key_ovf), 32'h0);

`ifdef KPD_AUTOREPEAT_EN
    // ---- auto-repeat: key 0 held, consumer always ready
    do_reset();
    key_ready = 1'b1;
    repeat (17) run_scan(16'h0001);
    repeat (20) run_scan(16'h0000);
    chk("rpt_cnt", 32'(rise_q.size()), 32'd4);
    chk("rpt_first", rise_at(1) - rise_at(0), 32'd100);
    chk("rpt_second", rise_at(2) - rise_at(0), 32'd140);
    chk("rpt_third", rise_at(3) - rise_at(0), 32'd180);
    for (int i = 0; i < 4; i++) chk($sformatf("rpt_code[%0d]", i), obs_at(i), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
